// File: rtl/telemetry_pkg.sv
// Common types and constants for the telemetry text overlay.
package telemetry_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef logic [7:0] char_t;

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_t;

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing parameter bundle used by the display-path blocks.
package vga_pkg;

  typedef struct packed {
    int unsigned pixel_x_bits;
    int unsigned pixel_y_bits;
  } vga_params_t;

  localparam vga_params_t VGA_640X480 = '{pixel_x_bits: 32'd10, pixel_y_bits: 32'd10};

endpackage

// File: rtl/font_rom_8x16.sv
// Compact 8x16 glyph ROM. Row 0 is the top scanline, bit 7 the leftmost pixel.
// Populated codes: space, '0', '1', 'A', 'B'; every other code renders a
// hollow box so unknown characters remain visible on screen.
module font_rom_8x16 (
  input  logic [7:0] code,
  input  logic [3:0] row,
  output logic [7:0] row_bits
);

  logic [127:0] glyph;

  // Whole glyph bitmap selected by character code, top row in the MSBs.
  always_comb begin
    glyph = 128'h007E_4242_4242_4242_4242_4242_4242_7E00;
    case (code)
      8'h20:   glyph = '0;
      8'h30:   glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      8'h31:   glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      8'h41:   glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      8'h42:   glyph = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      default: glyph = 128'h007E_4242_4242_4242_4242_4242_4242_7E00;
    endcase
  end

  // (15 - row) * 8 brings the requested scanline down to the low byte.
  assign row_bits = 8'(glyph >> {~row, 3'b000});

endmodule

// File: rtl/telemetry_geom.sv
// Combinational screen-to-grid decoder: which field/column/glyph pixel a
// coordinate lands on, or no hit for gaps, unused slots and off-grid points.
module telemetry_geom
  import telemetry_pkg::*;
#(
  parameter int XW               = 10,
  parameter int YW               = 10,
  parameter int BOX_X0           = 400,
  parameter int BOX_Y0           = 16,
  parameter int NUM_COLS         = 20,
  parameter int NUM_FIELDS       = 8,
  parameter int FIELDS_PER_LINE  = 4,
  parameter int TELE_SPACING_PIX = 8,
  parameter int LINE_SPACING_PIX = 4,
  parameter int SCALE_LOG2       = 0,
  parameter int FW               = 3,
  parameter int CLW              = 5
) (
  input  logic [XW-1:0]  pixel_x,
  input  logic [YW-1:0]  pixel_y,
  output logic           hit,
  output logic [FW-1:0]  field,
  output logic [CLW-1:0] col,
  output logic [2:0]     glyph_x,
  output logic [3:0]     glyph_y
);

  localparam int CW        = CHAR_W << SCALE_LOG2;
  localparam int CH        = CHAR_H << SCALE_LOG2;
  localparam int TW        = NUM_COLS * CW;
  localparam int SLOT_W    = TW + TELE_SPACING_PIX;
  localparam int LINE_H    = CH + LINE_SPACING_PIX;
  localparam int NUM_LINES = (NUM_FIELDS + FIELDS_PER_LINE - 1) / FIELDS_PER_LINE;

  logic [31:0] rel_x, rel_y;
  logic [31:0] slot, wx;
  logic [31:0] line_idx, wy;
  logic [31:0] fidx;

  // Split the box-relative position into slot/line and the offset inside it.
  always_comb begin
    rel_x    = 32'(pixel_x) - 32'(BOX_X0);
    rel_y    = 32'(pixel_y) - 32'(BOX_Y0);
    slot     = rel_x / 32'(SLOT_W);
    wx       = rel_x % 32'(SLOT_W);
    line_idx = rel_y / 32'(LINE_H);
    wy       = rel_y % 32'(LINE_H);
    fidx     = line_idx * 32'(FIELDS_PER_LINE) + slot;

    hit = (32'(pixel_x) >= 32'(BOX_X0)) && (32'(pixel_y) >= 32'(BOX_Y0)) &&
          (slot < 32'(FIELDS_PER_LINE)) && (wx < 32'(TW)) &&
          (line_idx < 32'(NUM_LINES)) && (wy < 32'(CH)) &&
          (fidx < 32'(NUM_FIELDS));

    // Misses report index 0 so the buffer read downstream is always in range.
    field   = hit ? FW'(fidx) : '0;
    col     = hit ? CLW'(wx / 32'(CW)) : '0;
    glyph_x = 3'(wx >> SCALE_LOG2);
    glyph_y = 4'(wy >> SCALE_LOG2);
  end

endmodule

// File: rtl/telemetry_grid.sv
// Telemetry text overlay: double-buffered character store, commit on frame
// boundary, per-field blink and a 2-stage coordinate-to-pixel pipeline.
//
// Commit FSM
//   state   | meaning
//   IDLE    | active buffer stable, producer may write the shadow buffer
//   PENDING | commit requested; writes stalled until the next frame_start swap
module telemetry_grid
  import telemetry_pkg::*;
#(
  parameter vga_pkg::vga_params_t params = vga_pkg::VGA_640X480,
  parameter int BOX_X0           = 400,
  parameter int BOX_Y0           = 16,
  parameter int NUM_COLS         = 20,
  parameter int NUM_FIELDS       = 8,
  parameter int FIELDS_PER_LINE  = 4,
  parameter int TELE_SPACING_PIX = 8,
  parameter int LINE_SPACING_PIX = 4,
  parameter int SCALE_LOG2       = 0,
  parameter int BLINK_LOG2       = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [params.pixel_x_bits-1:0]  pixel_x_target_next,
  input  logic [params.pixel_y_bits-1:0]  pixel_y_target_next,
  input  logic                            frame_start,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [$clog2(NUM_FIELDS)-1:0]   wr_field,
  input  logic [$clog2(NUM_COLS)-1:0]     wr_col,
  input  logic [7:0]                      wr_char,
  input  logic                            commit_req,
  input  logic [NUM_FIELDS-1:0]           blink_mask,
  output logic                            wr_err,
  output logic                            pixel_value_next,
  output logic                            in_grid
);

  localparam int XW  = int'(params.pixel_x_bits);
  localparam int YW  = int'(params.pixel_y_bits);
  localparam int FW  = $clog2(NUM_FIELDS);
  localparam int CLW = $clog2(NUM_COLS);

  commit_state_t state, state_next;
  logic          do_swap;

  char_t shadow [NUM_FIELDS][NUM_COLS];
  char_t active [NUM_FIELDS][NUM_COLS];

  logic wr_fire, wr_in_range;
  logic [BLINK_LOG2:0] blink_cnt;

  logic           g_hit;
  logic [FW-1:0]  g_field;
  logic [CLW-1:0] g_col;
  logic [2:0]     g_gx;
  logic [3:0]     g_gy;

  logic           s1_valid, s1_hit;
  logic [FW-1:0]  s1_field;
  logic [CLW-1:0] s1_col;
  logic [2:0]     s1_gx;
  logic [3:0]     s1_gy;

  char_t      s2_char;
  logic [7:0] s2_row;
  logic       s2_bit, s2_blank;

  assign wr_ready    = (state == IDLE);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (32'(wr_field) < 32'(NUM_FIELDS)) && (32'(wr_col) < 32'(NUM_COLS));

  // Commit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Commit next-state: a request while PENDING is absorbed, swap on frame_start.
  always_comb begin
    state_next = state;
    do_swap    = 1'b0;
    case (state)
      IDLE:    if (commit_req) state_next = PENDING;
      PENDING: if (frame_start) begin
        do_swap    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow buffer takes producer writes; active buffer is replaced wholesale on swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          shadow[f][c] <= CHAR_SPACE;
          active[f][c] <= CHAR_SPACE;
        end
      end
    end else begin
      if (do_swap) active <= shadow;
      if (wr_fire && wr_in_range) shadow[wr_field][wr_col] <= wr_char;
    end
  end

  // Flag writes that were accepted but addressed outside the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_fire && !wr_in_range;
  end

  // Free-running frame counter; its MSB is the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           blink_cnt <= '0;
    else if (frame_start) blink_cnt <= blink_cnt + 1'b1;
  end

  telemetry_geom #(
    .XW               (XW),
    .YW               (YW),
    .BOX_X0           (BOX_X0),
    .BOX_Y0           (BOX_Y0),
    .NUM_COLS         (NUM_COLS),
    .NUM_FIELDS       (NUM_FIELDS),
    .FIELDS_PER_LINE  (FIELDS_PER_LINE),
    .TELE_SPACING_PIX (TELE_SPACING_PIX),
    .LINE_SPACING_PIX (LINE_SPACING_PIX),
    .SCALE_LOG2       (SCALE_LOG2),
    .FW               (FW),
    .CLW              (CLW)
  ) u_geom (
    .pixel_x (pixel_x_target_next),
    .pixel_y (pixel_y_target_next),
    .hit     (g_hit),
    .field   (g_field),
    .col     (g_col),
    .glyph_x (g_gx),
    .glyph_y (g_gy)
  );

  // Stage 1: capture the decoded grid position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_field <= '0;
      s1_col   <= '0;
      s1_gx    <= '0;
      s1_gy    <= '0;
    end else begin
      s1_valid <= 1'b1;
      s1_hit   <= g_hit;
      s1_field <= g_field;
      s1_col   <= g_col;
      s1_gx    <= g_gx;
      s1_gy    <= g_gy;
    end
  end

  // Stage 2 lookup: character from the active buffer and the field's blink state.
  always_comb begin
    s2_char  = active[s1_field][s1_col];
    s2_blank = blink_cnt[BLINK_LOG2] && blink_mask[s1_field];
  end

  font_rom_8x16 u_font (
    .code     (s2_char),
    .row      (s1_gy),
    .row_bits (s2_row)
  );

  assign s2_bit = s2_row[~s1_gx];

  // Stage 2 register: blinked-off fields still report in_grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_value_next <= 1'b0;
      in_grid          <= 1'b0;
    end else begin
      pixel_value_next <= s1_valid && s1_hit && s2_bit && !s2_blank;
      in_grid          <= s1_valid && s1_hit;
    end
  end

endmodule

// File: tb/tb_telemetry_grid.sv
// Scoreboard bench for telemetry_grid: driver updates a field/array reference
// model and queues expected outputs; a monitor compares them when due.
module tb_telemetry_grid;

  localparam vga_pkg::vga_params_t TB_P = '{pixel_x_bits: 32'd11, pixel_y_bits: 32'd10};
  localparam int X0 = 400, Y0 = 16, NC = 20, NF = 8, FPL = 4, TS = 8, LS = 4, S = 0, BL = 1;
  localparam int CW = 8 << S, CH = 16 << S, TW = NC * CW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] px = '0;
  logic [9:0]  py = '0;
  logic        frame_start = 1'b0, wr_valid = 1'b0, commit_req = 1'b0;
  logic [2:0]  wr_field = '0;
  logic [4:0]  wr_col = '0;
  logic [7:0]  wr_char = '0;
  logic [7:0]  blink_mask = '0;
  logic        wr_ready, wr_err, pixel_value_next, in_grid;

  telemetry_grid #(
    .params (TB_P), .BOX_X0 (X0), .BOX_Y0 (Y0), .NUM_COLS (NC), .NUM_FIELDS (NF),
    .FIELDS_PER_LINE (FPL), .TELE_SPACING_PIX (TS), .LINE_SPACING_PIX (LS),
    .SCALE_LOG2 (S), .BLINK_LOG2 (BL)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .pixel_x_target_next (px), .pixel_y_target_next (py),
    .frame_start (frame_start), .wr_valid (wr_valid), .wr_ready (wr_ready),
    .wr_field (wr_field), .wr_col (wr_col), .wr_char (wr_char),
    .commit_req (commit_req), .blink_mask (blink_mask), .wr_err (wr_err),
    .pixel_value_next (pixel_value_next), .in_grid (in_grid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { int due; logic pv; logic ig; int x; int y; } pix_t;
  typedef struct { int due; logic err; } err_t;
  pix_t pix_q[$];
  err_t err_q[$];

  logic [7:0] m_shadow [NF][NC];
  logic [7:0] m_active [NF][NC];
  bit         m_pending;
  int         m_frames;

  function automatic logic [127:0] font_glyph(input logic [7:0] c);
    case (c)
      8'h20:   return '0;
      8'h30:   return 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      8'h31:   return 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      8'h41:   return 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      8'h42:   return 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      default: return 128'h007E_4242_4242_4242_4242_4242_4242_7E00;
    endcase
  endfunction

  function automatic logic font_bit(input logic [7:0] c, input int gy, input int gx);
    logic [127:0] g;
    logic [7:0]   r;
    g = font_glyph(c);
    r = g[(15 - gy) * 8 +: 8];
    return r[7 - gx];
  endfunction

  // Expected output for a coordinate: search every field's rectangle.
  function automatic void model_pix(input int x, input int y, output logic pv, output logic ig);
    pv = 1'b0;
    ig = 1'b0;
    for (int f = 0; f < NF; f++) begin
      int ox, oy, col, gx, gy;
      ox = X0 + (f % FPL) * (TW + TS);
      oy = Y0 + (f / FPL) * (CH + LS);
      if (x >= ox && x < ox + TW && y >= oy && y < oy + CH) begin
        col = (x - ox) / CW;
        gx  = ((x - ox) >> S) % 8;
        gy  = ((y - oy) >> S) % 16;
        ig  = 1'b1;
        pv  = font_bit(m_active[f][col], gy, gx) &&
              !((((m_frames >> BL) & 1) == 1) && blink_mask[f]);
      end
    end
  endfunction

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 5))
      0:       return 8'h20;
      1:       return 8'h30;
      2:       return 8'h31;
      3:       return 8'h41;
      4:       return 8'h42;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < NC; c++) begin
        m_shadow[f][c] = 8'h20;
        m_active[f][c] = 8'h20;
      end
    m_pending = 1'b0;
    m_frames  = 0;
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b", name, got, want);
    end
  endtask

  // One clock of stimulus, called just after a falling edge.
  task automatic step(input bit fs, input bit cr, input bit wv, input int wf, input int wc,
                      input logic [7:0] wch, input int x, input int y);
    pix_t pe;
    err_t ee;
    bit   acc;
    frame_start = fs;
    commit_req  = cr;
    wr_valid    = wv;
    wr_field    = 3'(wf);
    wr_col      = 5'(wc);
    wr_char     = wch;
    px          = 11'(x);
    py          = 10'(y);
    check1("wr_ready", wr_ready, !m_pending);
    acc    = wv && !m_pending;
    ee.due = cyc + 1;
    ee.err = acc && (wf >= NF || wc >= NC);
    if (m_pending && fs) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (!m_pending && cr) begin
      m_pending = 1'b1;
    end
    if (acc && wf < NF && wc < NC) m_shadow[wf][wc] = wch;
    if (fs) m_frames++;
    model_pix(x, y, pe.pv, pe.ig);
    pe.due = cyc + 2;
    pe.x   = x;
    pe.y   = y;
    pix_q.push_back(pe);
    err_q.push_back(ee);
    @(negedge clk);
  endtask

  task automatic idle(input int x, input int y);
    step(0, 0, 0, 0, 0, 8'h00, x, y);
  endtask

  task automatic scan(input int xa, input int xb, input int xs, input int ya, input int yb);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x += xs)
        idle(x, y);
  endtask

  // Let in-flight expectations retire while inputs stay quiet.
  task automatic flush();
    frame_start = 1'b0;
    commit_req  = 1'b0;
    wr_valid    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare whatever expectations fall due on this cycle.
  initial begin
    pix_t pe;
    err_t ee;
    forever begin
      @(posedge clk);
      #1;
      while (pix_q.size() != 0 && pix_q[0].due <= cyc) begin
        pe = pix_q.pop_front();
        n_vec++;
        if (pixel_value_next !== pe.pv || in_grid !== pe.ig) begin
          n_bad++;
          $display("FAIL pixel (%0d,%0d): got pv=%0b ig=%0b, want pv=%0b ig=%0b",
                   pe.x, pe.y, pixel_value_next, in_grid, pe.pv, pe.ig);
        end
      end
      while (err_q.size() != 0 && err_q[0].due <= cyc) begin
        ee = err_q.pop_front();
        n_vec++;
        if (wr_err !== ee.err) begin
          n_bad++;
          $display("FAIL wr_err @cyc %0d: got %0b, want %0b", cyc, wr_err, ee.err);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check1("reset pixel", pixel_value_next, 1'b0);
    check1("reset in_grid", in_grid, 1'b0);
    check1("reset wr_ready", wr_ready, 1'b1);
    check1("reset wr_err", wr_err, 1'b0);
    rst_n = 1'b1;

    // Fresh grid: spaces everywhere, in_grid only over the eight cells.
    scan(X0 - 4, X0 + 4 * (TW + TS), 3, Y0 - 4, Y0 + 2 * (CH + LS));

    // 'A' into field 5 col 0; invisible until the commit meets frame_start.
    step(0, 0, 1, 5, 0, 8'h41, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    scan(X0 + TW + TS - 4, X0 + TW + TS + 12, 1, Y0 + CH + LS - 2, Y0 + 2 * CH + LS + 1);
    step(1, 0, 0, 0, 0, 8'h00, X0 + TW + TS + 3, Y0 + CH + LS + 7);
    scan(X0 + TW + TS - 4, X0 + TW + TS + 12, 1, Y0 + CH + LS - 2, Y0 + 2 * CH + LS + 1);

    // Writes stall while a commit is pending and land right after the swap.
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, (i == 2), 1, 2, 3, 8'h42, X0 + 5, Y0 + 5);
    step(1, 0, 1, 2, 3, 8'h42, X0 + 5, Y0 + 5);
    step(0, 0, 1, 2, 3, 8'h42, X0 + 5, Y0 + 5);
    idle(0, 0);

    // Column range boundary: 19 accepted, 20 and 31 flagged and dropped.
    step(0, 0, 1, 4, 19, 8'h30, 0, 0);
    step(0, 0, 1, 4, 20, 8'h31, 0, 0);
    step(0, 0, 1, 7, 31, 8'h31, 0, 0);
    idle(0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    scan(X0 + 2 * (TW + TS) + 20, X0 + 2 * (TW + TS) + 35, 1, Y0, Y0 + CH - 1);
    scan(X0 + TW - 10, X0 + TW + TS + 2, 1, Y0 + CH + LS, Y0 + 2 * CH + LS - 1);

    // Blink: field 0 masked, field 1 not; both hold 'A' in col 0.
    step(0, 0, 1, 0, 0, 8'h41, 0, 0);
    step(0, 0, 1, 1, 0, 8'h41, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 0, 8'h00, X0 + 2, Y0 + 6);
    flush();
    blink_mask = 8'h01;
    for (int fr = 0; fr < 8; fr++) begin
      step(1, 0, 0, 0, 0, 8'h00, X0 + 1, Y0 + 7);
      scan(X0, X0 + 7, 1, Y0 + 4, Y0 + 8);
      scan(X0 + TW + TS, X0 + TW + TS + 7, 1, Y0 + 4, Y0 + 8);
    end

    // Randomised traffic against the model.
    flush();
    blink_mask = 8'hA5;
    for (int i = 0; i < 3000; i++) begin
      bit fs, cr, wv;
      int wc;
      fs = ($urandom_range(0, 59) == 0);
      cr = ($urandom_range(0, 39) == 0);
      wv = ($urandom_range(0, 3) == 0);
      wc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
      step(fs, cr, wv, int'($urandom_range(0, 7)), wc, rand_char(),
           int'($urandom_range(X0 - 4, X0 + 4 * (TW + TS))),
           int'($urandom_range(Y0 - 4, Y0 + 2 * (CH + LS))));
    end

    // Reset during PENDING: commit lost, buffers back to spaces.
    flush();
    step(0, 0, 1, 3, 2, 8'h42, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    idle(X0 + 1, Y0 + 1);
    flush();
    rst_n = 1'b0;
    #1;
    check1("async reset in_grid", in_grid, 1'b0);
    check1("async reset pixel", pixel_value_next, 1'b0);
    check1("async reset wr_ready", wr_ready, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 8'h00, X0 + 3 * (TW + TS) + 17, Y0 + 5);
    scan(X0 + 3 * (TW + TS) + 16, X0 + 3 * (TW + TS) + 23, 1, Y0, Y0 + CH - 1);

    flush();
    n_vec++;
    if (pix_q.size() != 0 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pixel / %0d err expectations never compared, want 0",
               pix_q.size(), err_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
